cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl -- run control and debug-read sequencer for a small CPU.
//
// Gates the CPU subsystem clock-enable so the core can run freely, execute
// a fixed number of steps, or stop at a halt request or a PC breakpoint.
// While the core is halted, a debug read of the register file, data memory
// or instruction memory is sequenced through the subsystem debug port.
//
// Ports
//   clk, reset           single clock; synchronous active-high reset
//   run_req, halt_req,
//   step_req             single-cycle run-control pulses
//   step_count           cycles to execute per step (0 behaves as 1)
//   bp_enable, bp_addr   PC breakpoint controls
//   pc                   current program counter from the subsystem
//   cpu_en               subsystem clock-enable (one instruction per cycle)
//   dbg_req_*            debug read request handshake (sel: 0 reg, 1 dmem,
//                        2 imem, 3 reserved -> reads 0)
//   dbg_rsp_valid/data   debug read response, data zero-extended to INST_W
//   debug_enable,
//   *_debug_addr         address side of the subsystem debug port
//   *_debug_rdata        read data returned by the subsystem debug port
//   halted, bp_hit       status (bp_hit is sticky until the next run/step)
//   state                FSM state: 0 HALTED, 1 RUN, 2 STEP, 3 DBG_ADDR,
//                        4 DBG_DATA
// ============================================================================
module cpu_run_ctrl #(
    parameter int I_ADDR_W       = 12,
    parameter int D_ADDR_W       = 12,
    parameter int DATA_W         = 8,
    parameter int INST_W         = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int STEP_W         = 8,
    parameter int DBG_RD_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run_req,
    input  logic                      halt_req,
    input  logic                      step_req,
    input  logic [STEP_W-1:0]         step_count,
    input  logic                      bp_enable,
    input  logic [I_ADDR_W-1:0]       bp_addr,
    input  logic [I_ADDR_W-1:0]       pc,
    output logic                      cpu_en,
    input  logic                      dbg_req_valid,
    output logic                      dbg_req_ready,
    input  logic [1:0]                dbg_req_sel,
    input  logic [11:0]               dbg_req_addr,
    output logic                      dbg_rsp_valid,
    output logic [INST_W-1:0]         dbg_rsp_data,
    output logic                      debug_enable,
    output logic [REG_ADDR_WIDTH-1:0] reg_debug_addr,
    output logic [D_ADDR_W-1:0]       dmem_debug_addr,
    output logic [I_ADDR_W-1:0]       imem_debug_addr,
    input  logic [DATA_W-1:0]         reg_debug_rdata,
    input  logic [DATA_W-1:0]         dmem_debug_rdata,
    input  logic [INST_W-1:0]         imem_debug_rdata,
    output logic                      halted,
    output logic                      bp_hit,
    output logic [2:0]                state
);

    typedef enum logic [2:0] {
        S_HALTED   = 3'd0,
        S_RUN      = 3'd1,
        S_STEP     = 3'd2,
        S_DBG_ADDR = 3'd3,
        S_DBG_DATA = 3'd4
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(DBG_RD_LAT - 1);

    state_t              cur_state;
    state_t              nxt_state;
    logic [STEP_W-1:0]   step_cnt;
    logic [2:0]          lat_cnt;
    logic [1:0]          sel_q;
    logic [11:0]         addr_q;
    logic                resume_q;   // first cycle of RUN/STEP after HALTED
    logic                bp_cond;
    logic                bp_set;
    logic                accept_run;
    logic                accept_step;
    logic                accept_dbg;
    logic                dbg_active;

    // Breakpoint is masked on the first cycle after resuming so that the
    // instruction sitting at bp_addr is executed rather than re-trapped.
    assign bp_cond = bp_enable && (pc == bp_addr) && !resume_q;

    // NOTE: every output of this block is given a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        nxt_state     = cur_state;
        cpu_en        = 1'b0;
        dbg_req_ready = 1'b0;
        accept_run    = 1'b0;
        accept_step   = 1'b0;
        accept_dbg    = 1'b0;
        bp_set        = 1'b0;
        case (cur_state)
            S_HALTED: begin
                dbg_req_ready = !run_req && !step_req;
                if (step_req) begin
                    accept_step = 1'b1;
                    nxt_state   = S_STEP;
                end else if (run_req) begin
                    accept_run = 1'b1;
                    nxt_state  = S_RUN;
                end else if (dbg_req_valid) begin
                    accept_dbg = 1'b1;
                    nxt_state  = S_DBG_ADDR;
                end
            end
            S_RUN, S_STEP: begin
                // halt_req wins over both the breakpoint and step completion
                if (halt_req) begin
                    nxt_state = S_HALTED;
                end else if (bp_cond) begin
                    bp_set    = 1'b1;
                    nxt_state = S_HALTED;
                end else begin
                    cpu_en = 1'b1;
                    if (cur_state == S_STEP && step_cnt <= STEP_W'(1))
                        nxt_state = S_HALTED;
                end
            end
            S_DBG_ADDR: begin
                if (lat_cnt == LAT_LAST)
                    nxt_state = S_DBG_DATA;
            end
            S_DBG_DATA: nxt_state = S_HALTED;
            default:    nxt_state = S_HALTED;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) cur_state <= S_HALTED;
        else       cur_state <= nxt_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt      <= '0;
            lat_cnt       <= '0;
            sel_q         <= '0;
            addr_q        <= '0;
            resume_q      <= 1'b0;
            bp_hit        <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_data  <= '0;
        end else begin
            resume_q      <= accept_run || accept_step;
            dbg_rsp_valid <= 1'b0;

            if (accept_step)
                step_cnt <= (step_count == '0) ? STEP_W'(1) : step_count;
            else if (cur_state == S_STEP && cpu_en)
                step_cnt <= step_cnt - STEP_W'(1);

            if (accept_run || accept_step) bp_hit <= 1'b0;
            else if (bp_set)               bp_hit <= 1'b1;

            if (accept_dbg) begin
                sel_q   <= dbg_req_sel;
                addr_q  <= dbg_req_addr;
                lat_cnt <= '0;
            end else if (cur_state == S_DBG_ADDR) begin
                lat_cnt <= lat_cnt + 3'd1;
            end

            if (cur_state == S_DBG_DATA) begin
                dbg_rsp_valid <= 1'b1;
                case (sel_q)
                    2'd0:    dbg_rsp_data <= INST_W'(reg_debug_rdata);
                    2'd1:    dbg_rsp_data <= INST_W'(dmem_debug_rdata);
                    2'd2:    dbg_rsp_data <= imem_debug_rdata;
                    default: dbg_rsp_data <= '0;
                endcase
            end
        end
    end

    // The address is held through DBG_DATA as well so that a memory with a
    // combinational read path still presents valid data when it is captured.
    assign dbg_active      = (cur_state == S_DBG_ADDR) || (cur_state == S_DBG_DATA);
    assign debug_enable    = dbg_active;
    assign reg_debug_addr  = (dbg_active && sel_q == 2'd0) ? REG_ADDR_WIDTH'(addr_q) : '0;
    assign dmem_debug_addr = (dbg_active && sel_q == 2'd1) ? D_ADDR_W'(addr_q) : '0;
    assign imem_debug_addr = (dbg_active && sel_q == 2'd2) ? I_ADDR_W'(addr_q) : '0;

    assign halted = (cur_state == S_HALTED);
    assign state  = cur_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl -- self-checking bench for cpu_run_ctrl.
//
// A cycle-level behavioural model (mode, steps remaining, pending debug read
// with its due cycle) predicts every output each cycle. Stimulus is a vector
// table, directed breakpoint/debug/reset sequences, then random traffic.
// A tiny CPU stand-in advances pc on cpu_en; the debug memories are simple
// functions of the presented address.
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int DBG_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_req, halt_req, step_req;
    logic [7:0]  step_count;
    logic        bp_enable;
    logic [11:0] bp_addr;
    logic [11:0] pc;
    logic        cpu_en;
    logic        dbg_req_valid, dbg_req_ready;
    logic [1:0]  dbg_req_sel;
    logic [11:0] dbg_req_addr;
    logic        dbg_rsp_valid;
    logic [15:0] dbg_rsp_data;
    logic        debug_enable;
    logic [3:0]  reg_debug_addr;
    logic [11:0] dmem_debug_addr, imem_debug_addr;
    logic [7:0]  reg_debug_rdata, dmem_debug_rdata;
    logic [15:0] imem_debug_rdata;
    logic        halted, bp_hit;
    logic [2:0]  state;

    logic        pc_load;
    logic [11:0] pc_val;

    cpu_run_ctrl #(.DBG_RD_LAT(DBG_LAT)) dut (
        .clk(clk), .reset(reset),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .step_count(step_count), .bp_enable(bp_enable), .bp_addr(bp_addr),
        .pc(pc), .cpu_en(cpu_en),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_sel(dbg_req_sel), .dbg_req_addr(dbg_req_addr),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data),
        .debug_enable(debug_enable), .reg_debug_addr(reg_debug_addr),
        .dmem_debug_addr(dmem_debug_addr), .imem_debug_addr(imem_debug_addr),
        .reg_debug_rdata(reg_debug_rdata), .dmem_debug_rdata(dmem_debug_rdata),
        .imem_debug_rdata(imem_debug_rdata),
        .halted(halted), .bp_hit(bp_hit), .state(state)
    );

    always #5 clk = ~clk;

    // CPU stand-in: one instruction per enabled cycle
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_val;
        else if (cpu_en) pc <= pc + 12'd1;
    end

    // Debug memories: combinational functions of the address
    assign reg_debug_rdata  = {4'hC, reg_debug_addr};
    assign dmem_debug_rdata = dmem_debug_addr[7:0] ^ 8'h86;
    assign imem_debug_rdata = {imem_debug_addr, 4'h5};

    function automatic logic [15:0] mem_value(input logic [1:0] sel, input logic [11:0] addr);
        case (sel)
            2'd0:    return {8'h00, 4'hC, addr[3:0]};
            2'd1:    return {8'h00, addr[7:0] ^ 8'h86};
            2'd2:    return {addr, 4'h5};
            default: return 16'h0000;
        endcase
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {M_HALT, M_RUN, M_STEP, M_DBG} mode_t;
    mode_t       m_mode;
    int          m_steps_left;
    int          m_acc_cyc;
    bit          m_fresh;
    bit          m_bp_hit;
    bit          m_rsp_valid;
    logic [15:0] m_rsp_data;
    logic [1:0]  m_sel;
    logic [11:0] m_addr;

    task automatic model_reset();
        m_mode = M_HALT; m_steps_left = 0; m_fresh = 0; m_bp_hit = 0;
        m_rsp_valid = 0; m_rsp_data = '0; m_sel = '0; m_addr = '0; m_acc_cyc = 0;
    endtask

    // optional per-row expectations from the vector table
    bit          row_active;
    logic        row_en, row_ready;
    logic [2:0]  row_state;

    task automatic clear_pulses();
        run_req = 0; step_req = 0; halt_req = 0; dbg_req_valid = 0;
        reset = 0; pc_load = 0; row_active = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, then
    // return just after the rising edge with the pulses cleared.
    task automatic tick();
        logic [2:0] e_state;
        bit active, bp_now, e_en, e_ready, in_dbg;
        @(negedge clk);
        case (m_mode)
            M_HALT:  e_state = 3'd0;
            M_RUN:   e_state = 3'd1;
            M_STEP:  e_state = 3'd2;
            default: e_state = (cyc - m_acc_cyc <= DBG_LAT) ? 3'd3 : 3'd4;
        endcase
        active  = (m_mode == M_RUN) || (m_mode == M_STEP);
        bp_now  = bp_enable && (pc == bp_addr) && !m_fresh;
        e_en    = active && !halt_req && !bp_now;
        e_ready = (m_mode == M_HALT) && !run_req && !step_req;
        in_dbg  = (m_mode == M_DBG);

        check("state", 32'(state), 32'(e_state));
        check("halted", 32'(halted), 32'(m_mode == M_HALT));
        check("cpu_en", 32'(cpu_en), 32'(e_en));
        check("dbg_req_ready", 32'(dbg_req_ready), 32'(e_ready));
        check("bp_hit", 32'(bp_hit), 32'(m_bp_hit));
        check("debug_enable", 32'(debug_enable), 32'(in_dbg));
        check("dbg_rsp_valid", 32'(dbg_rsp_valid), 32'(m_rsp_valid));
        check("dbg_rsp_data", 32'(dbg_rsp_data), 32'(m_rsp_data));
        check("reg_debug_addr", 32'(reg_debug_addr),
              (in_dbg && m_sel == 2'd0) ? 32'(m_addr[3:0]) : 32'd0);
        check("dmem_debug_addr", 32'(dmem_debug_addr),
              (in_dbg && m_sel == 2'd1) ? 32'(m_addr) : 32'd0);
        check("imem_debug_addr", 32'(imem_debug_addr),
              (in_dbg && m_sel == 2'd2) ? 32'(m_addr) : 32'd0);
        if (row_active) begin
            check("vec_state", 32'(state), 32'(row_state));
            check("vec_cpu_en", 32'(cpu_en), 32'(row_en));
            check("vec_ready", 32'(dbg_req_ready), 32'(row_ready));
        end

        if (reset) begin
            model_reset();
        end else begin
            m_fresh     = 0;
            m_rsp_valid = 0;
            case (m_mode)
                M_HALT: begin
                    if (step_req) begin
                        m_mode = M_STEP; m_bp_hit = 0; m_fresh = 1;
                        m_steps_left = (step_count == 0) ? 1 : int'(step_count);
                    end else if (run_req) begin
                        m_mode = M_RUN; m_bp_hit = 0; m_fresh = 1;
                    end else if (dbg_req_valid) begin
                        m_mode = M_DBG; m_acc_cyc = cyc;
                        m_sel = dbg_req_sel; m_addr = dbg_req_addr;
                    end
                end
                M_RUN, M_STEP: begin
                    if (halt_req) begin
                        m_mode = M_HALT;
                    end else if (bp_now) begin
                        m_mode = M_HALT; m_bp_hit = 1;
                    end else if (m_mode == M_STEP) begin
                        m_steps_left--;
                        if (m_steps_left == 0) m_mode = M_HALT;
                    end
                end
                default: begin
                    if (cyc - m_acc_cyc == DBG_LAT + 1) begin
                        m_mode = M_HALT; m_rsp_valid = 1;
                        m_rsp_data = mem_value(m_sel, m_addr);
                    end
                end
            endcase
        end
        @(posedge clk);
        cyc++;
        #1;
        clear_pulses();
    endtask

    task automatic do_reset();
        reset = 1; pc_load = 1; pc_val = '0;
        tick();
        tick();
    endtask

    typedef struct {
        logic       run, step, halt, dv;
        logic [7:0] sc;
        logic       e_en, e_ready;
        logic [2:0] e_state;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit done;
        logic [11:0] p0;

        // run, step, halt, dv, step_count | cpu_en, ready, state
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 3'd0}; // step 3
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd2};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd2};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 3'd0}; // run wins over dbg
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 3'd1}; // halt gates cpu_en
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0}; // step 0 -> 1
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd2};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 3'd0};

        clear_pulses();
        step_count = '0; bp_enable = 0; bp_addr = '0;
        dbg_req_sel = '0; dbg_req_addr = '0; pc_val = '0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // reset state
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_rsp_data", 32'(dbg_rsp_data), 32'd0);

        // ---- vector table ----
        foreach (vecs[i]) begin
            run_req = vecs[i].run; step_req = vecs[i].step; halt_req = vecs[i].halt;
            dbg_req_valid = vecs[i].dv; step_count = vecs[i].sc;
            row_active = 1; row_en = vecs[i].e_en; row_ready = vecs[i].e_ready;
            row_state = vecs[i].e_state;
            tick();
        end

        // ---- breakpoint at 0x010, resume executes it ----
        do_reset();
        bp_enable = 1; bp_addr = 12'h010;
        run_req = 1; tick();
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            done = halted && bp_hit;
        end
        check("bp_stop_reached", 32'(done), 32'd1);
        check("bp_stop_pc", 32'(pc), 32'h010);
        run_req = 1; tick();
        check("bp_cleared", 32'(bp_hit), 32'd0);
        tick();
        check("bp_resume_pc", 32'(pc), 32'h011);
        halt_req = 1; tick();
        tick();

        // ---- halt and breakpoint in the same cycle ----
        p0 = pc;
        bp_addr = p0 + 12'd2;
        run_req = 1; tick();
        tick();
        tick();
        check("pc_at_bp", 32'(pc), 32'(p0 + 12'd2));
        halt_req = 1; tick();
        tick();
        check("halt_over_bp", 32'(bp_hit), 32'd0);
        check("halt_over_bp_halted", 32'(halted), 32'd1);
        bp_enable = 0;

        // ---- debug read dmem 0x123 ----
        dbg_req_valid = 1; dbg_req_sel = 2'd1; dbg_req_addr = 12'h123;
        tick();
        check("dbg_en_addr", 32'(debug_enable), 32'd1);
        check("dbg_dmem_addr", 32'(dmem_debug_addr), 32'h123);
        tick();
        tick();
        check("dbg_rsp_valid_t3", 32'(dbg_rsp_valid), 32'd1);
        check("dbg_rsp_data_t3", 32'(dbg_rsp_data), 32'h00A5);
        tick();
        check("dbg_rsp_hold", 32'(dbg_rsp_data), 32'h00A5);

        // ---- reset during DBG_ADDR ----
        dbg_req_valid = 1; dbg_req_sel = 2'd2; dbg_req_addr = 12'h3C7;
        tick();
        check("abort_in_dbg_addr", 32'(state), 32'd3);
        reset = 1; tick();
        check("abort_state", 32'(state), 32'd0);
        check("abort_dbg_en", 32'(debug_enable), 32'd0);
        check("abort_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
        tick();
        tick();

        // ---- random traffic against the model ----
        for (int i = 0; i < 4000; i++) begin
            run_req       = ($urandom_range(0, 99) < 10);
            step_req      = ($urandom_range(0, 99) < 8);
            halt_req      = ($urandom_range(0, 99) < 6);
            dbg_req_valid = ($urandom_range(0, 99) < 30);
            dbg_req_sel   = 2'($urandom_range(0, 3));
            dbg_req_addr  = 12'($urandom);
            step_count    = 8'($urandom_range(0, 5));
            reset         = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 99) < 5) bp_enable = ~bp_enable;
            if ($urandom_range(0, 99) < 5) bp_addr = 12'($urandom_range(0, 40));
            if ($urandom_range(0, 99) < 2) begin
                pc_load = 1; pc_val = 12'($urandom_range(0, 40));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
